seg_scan_display: RTL and testbench

- Parametrised multi-digit 7-segment scan driver; successor to the two-digit hex scanner.
- Scans SEL_W common-anode digits at a programmable rate.
- Displays data as hex nibbles, or as decimal via an on-board sequential binary-to-BCD converter.
- Adds a valid/ready load handshake, overflow indication, leading-zero blanking, per-digit decimal points and whole-display blink.
- Sits between the data-producing logic (e.g. IIC read path) and the board's SEL/DIG pins.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_scan_display_bin2bcd.sv | 86 ++++++++
 rtl/seg_scan_display.sv | 149 ++++++++++++++
 tb/tb_seg_scan_display.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment encodings, hex decoder and converter state type for the
// multi-digit 7-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is left off (1).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one iteration per clk.
// Final result and overflow are presented combinationally on the last iteration.
module bin2bcd_seq #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SEL_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    bin_i,
  output logic                 busy_o,
  output logic                 done_c,
  output logic [4*SEL_W-1:0]   bcd_c,
  output logic                 ovf_c
);
  import seg_pkg::*;

  localparam int unsigned BCD_W = 4 * SEL_W;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  conv_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj, shifted;
  logic               carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_c  = 1'b0;
    adj     = bcd_q;
    // Add 3 to every digit >= 5 so the following shift carries correctly.
    for (int i = 0; i < int'(SEL_W); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BCD_W-2:0], sh_q[DATA_W-1]};
    carry   = adj[BCD_W-1];
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CONV;
          cnt_d   = '0;
          sh_d    = bin_i;
          bcd_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CONV: begin
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        bcd_d = shifted;
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    bcd_c  = shifted;
    ovf_c  = ovf_q | carry;
    busy_o = (state_q == CONV);
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit common-anode 7-segment scan driver with hex/decimal load,
// overflow dashes, leading-zero blanking, decimal points and blink.
module seg_scan_display #(
  parameter int unsigned SEL_W     = 6,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned SCAN_CNT  = 50000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  input  logic              mode,
  input  logic [SEL_W-1:0]  dp_mask,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic [SEL_W-1:0]  SEL,
  output logic [7:0]        DIG
);
  import seg_pkg::*;

  localparam int unsigned SCAN_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int unsigned IDX_W  = (SEL_W > 1) ? $clog2(SEL_W) : 1;
  localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              ovf_q, ovf_d;
  logic              rdy_q, rdy_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        dig_q, dig_d;

  logic              accept_c, tick_c;
  logic              conv_busy, conv_done_c, conv_ovf_c;
  logic [DATA_W-1:0] conv_bcd_c;
  logic [3:0]        nib;
  logic              dp_bit, lz_bit, zero_run;
  logic [SEL_W-1:0]  lz_vec, sel_pat;
  logic [7:0]        seg;

  assign accept_c = din_vld & rdy_q;
  assign tick_c   = (scan_q == SCAN_W'(SCAN_CNT - 1));

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept_c & mode),
    .bin_i   (din),
    .busy_o  (conv_busy),
    .done_c  (conv_done_c),
    .bcd_c   (conv_bcd_c),
    .ovf_c   (conv_ovf_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      buf_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
      sel_q   <= '1;
      dig_q   <= SEG_BLANK;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      buf_q   <= buf_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      sel_q   <= sel_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    scan_d   = scan_q + SCAN_W'(1);
    idx_d    = idx_q;
    blk_d    = blk_q;
    phase_d  = phase_q;
    buf_d    = buf_q;
    ovf_d    = ovf_q;
    sel_d    = sel_q;
    dig_d    = dig_q;
    nib      = '0;
    dp_bit   = 1'b0;
    lz_bit   = 1'b0;
    zero_run = 1'b1;
    lz_vec   = '0;
    sel_pat  = '1;

    // Hex loads land immediately; decimal results land atomically on conversion end.
    if (accept_c && !mode) begin
      buf_d = din;
      ovf_d = 1'b0;
    end else if (conv_done_c) begin
      buf_d = conv_bcd_c;
      ovf_d = conv_ovf_c;
    end
    rdy_d = ~((accept_c & mode) | (conv_busy & ~conv_done_c));

    for (int i = int'(SEL_W) - 1; i > 0; i--) begin
      zero_run  = zero_run & (buf_q[4*i +: 4] == 4'd0);
      lz_vec[i] = zero_run;
    end
    for (int i = 0; i < int'(SEL_W); i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib                 = buf_q[4*i +: 4];
        dp_bit              = dp_mask[i];
        lz_bit              = lz_vec[i];
        sel_pat[SEL_W-1-i]  = 1'b0;
      end
    end

    if (ovf_q)                 seg = SEG_DASH;
    else if (blank_lz && lz_bit) seg = SEG_BLANK;
    else                       seg = hex_to_seg(nib);
    if (dp_bit) seg[7] = 1'b0;

    // SEL and DIG change together on the scan tick for the digit being left.
    if (tick_c) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(SEL_W - 1)) ? '0 : idx_q + IDX_W'(1);
      if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BLK_W'(1);
      end
      sel_d = (blink_en && !phase_q) ? '1 : sel_pat;
      dig_d = seg;
    end
  end

  assign din_rdy = rdy_q;
  assign SEL     = sel_q;
  assign DIG     = dig_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: expected digit codes are queued at
// load time and popped as each scanned digit appears on SEL/DIG.
module tb_seg_scan_display;

  localparam int SEL_W  = 6;
  localparam int DATA_W = 24;
  localparam int SCAN   = 4;
  localparam int BLINK  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_rdy;
  logic              mode;
  logic [SEL_W-1:0]  dp_mask;
  logic              blank_lz;
  logic              blink_en;
  logic [SEL_W-1:0]  SEL;
  logic [7:0]        DIG;

  int tests = 0;
  int fails = 0;
  int cyc;

  logic [7:0]       exp_q[$];
  logic [7:0]       shown[SEL_W];
  logic [SEL_W-1:0] cap_sel[SEL_W];
  logic [7:0]       cap_dig[SEL_W];

  always #5 clk = ~clk;

  seg_scan_display #(
    .SEL_W(SEL_W), .DATA_W(DATA_W), .SCAN_CNT(SCAN), .BLINK_DIV(BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .mode(mode), .dp_mask(dp_mask), .blank_lz(blank_lz), .blink_en(blink_en),
    .SEL(SEL), .DIG(DIG)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] t[16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  function automatic logic [SEL_W-1:0] sel_for(input int d);
    logic [SEL_W-1:0] s;
    s = '1;
    s[SEL_W-1-d] = 1'b0;
    return s;
  endfunction

  function automatic void push_frame(input logic [DATA_W-1:0] v, input logic dec,
                                     input logic blz, input logic [SEL_W-1:0] dp);
    int dg[SEL_W];
    int hi;
    logic ovf;
    logic [7:0] s;
    ovf = dec && (int'(v) >= 10**SEL_W);
    hi  = 0;
    for (int i = 0; i < SEL_W; i++) begin
      dg[i] = dec ? (int'(v) / (10**i)) % 10 : int'(v[4*i +: 4]);
      if (dg[i] != 0) hi = i;
    end
    for (int i = 0; i < SEL_W; i++) begin
      if (ovf)                s = 8'hBF;
      else if (blz && i > hi) s = 8'hFF;
      else                    s = hex_seg(4'(dg[i]));
      if (dp[i]) s[7] = 1'b0;
      exp_q.push_back(s);
      shown[i] = s;
    end
  endfunction

  task automatic wait_slot();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % SCAN != 0);
  endtask

  task automatic capture_frame();
    int n = 0;
    do begin
      wait_slot();
      n++;
    end while ((((cyc / SCAN) - 1) % SEL_W) != 0 && n < 2 * SEL_W);
    for (int d = 0; d < SEL_W; d++) begin
      if (d > 0) wait_slot();
      cap_sel[d] = SEL;
      cap_dig[d] = DIG;
    end
  endtask

  task automatic load(input logic [DATA_W-1:0] v, input logic m);
    logic ok;
    int n = 0;
    din = v; mode = m; din_vld = 1'b1;
    do begin
      ok = din_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    din_vld = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL load_accept: din_rdy %b after %0d cycles, want 1", din_rdy, n); end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (din_rdy !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (din_rdy !== 1'b1) begin fails++; $display("FAIL rdy_timeout: din_rdy %b, want 1", din_rdy); end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; din = '0; din_vld = 1'b0; mode = 1'b0;
    dp_mask = '0; blank_lz = 1'b0; blink_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (SEL !== 6'h3F) begin fails++; $display("FAIL reset_sel: got %h want 3f", SEL); end
    tests++; if (DIG !== 8'hFF) begin fails++; $display("FAIL reset_dig: got %h want ff", DIG); end
    tests++; if (din_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", din_rdy); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c < SCAN; c++) begin
      @(posedge clk);
      #1;
      tests++; if (SEL !== 6'h3F) begin fails++; $display("FAIL pre_tick_sel cyc%0d: got %h want 3f", cyc, SEL); end
    end
    push_frame('0, 1'b0, 1'b0, '0);
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL reset_frame DIG%0d: got %h want %h", d, cap_dig[d], e); end
      tests++; if (cap_sel[d] !== sel_for(d)) begin fails++; $display("FAIL reset_frame SEL%0d: got %b want %b", d, cap_sel[d], sel_for(d)); end
    end
  endtask

  task automatic test_hex();
    logic [7:0] e;
    int drops = 0;
    push_frame(24'h12AB3F, 1'b0, 1'b0, '0);
    load(24'h12AB3F, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (din_rdy !== 1'b1) drops++;
      @(posedge clk);
      #1;
    end
    tests++; if (drops != 0) begin fails++; $display("FAIL hex_rdy_drop: got %0d low cycles want 0", drops); end
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL hex DIG%0d: got %h want %h", d, cap_dig[d], e); end
      tests++; if (cap_sel[d] !== sel_for(d)) begin fails++; $display("FAIL hex SEL%0d: got %b want %b", d, cap_sel[d], sel_for(d)); end
    end
  endtask

  task automatic test_decimal();
    logic [7:0] e;
    logic [7:0] old[SEL_W];
    int low = 0;
    old = shown;
    push_frame(24'd123456, 1'b1, 1'b0, '0);
    wait_slot();
    din = 24'd123456; mode = 1'b1; din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0; mode = 1'b0;
    tests++; if (din_rdy !== 1'b0) begin fails++; $display("FAIL dec_rdy_drop: got %b want 0", din_rdy); end
    for (int c = 0; c < 40; c++) begin
      if (din_rdy === 1'b0) begin
        low++;
        if (cyc % SCAN == 0) begin
          e = old[((cyc / SCAN) - 1) % SEL_W];
          tests++; if (DIG !== e) begin fails++; $display("FAIL dec_hold DIG cyc%0d: got %h want %h", cyc, DIG, e); end
        end
      end
      @(posedge clk);
      #1;
    end
    tests++; if (low != DATA_W) begin fails++; $display("FAIL dec_rdy_low: got %0d cycles want %0d", low, DATA_W); end
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL dec DIG%0d: got %h want %h", d, cap_dig[d], e); end
      tests++; if (cap_sel[d] !== sel_for(d)) begin fails++; $display("FAIL dec SEL%0d: got %b want %b", d, cap_sel[d], sel_for(d)); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] e;
    logic [DATA_W-1:0] vals[2];
    vals = '{24'd1000000, 24'd999999};
    for (int v = 0; v < 2; v++) begin
      push_frame(vals[v], 1'b1, 1'b0, '0);
      load(vals[v], 1'b1);
      wait_rdy();
      capture_frame();
      for (int d = 0; d < SEL_W; d++) begin
        e = exp_q.pop_front();
        tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL ovf%0d DIG%0d: got %h want %h", v, d, cap_dig[d], e); end
      end
    end
  endtask

  task automatic test_blank_dp();
    logic [7:0] e;
    blank_lz = 1'b1; dp_mask = 6'b000010;
    push_frame(24'd42, 1'b1, 1'b1, 6'b000010);
    load(24'd42, 1'b1);
    wait_rdy();
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL blank_dp DIG%0d: got %h want %h", d, cap_dig[d], e); end
      tests++; if (cap_sel[d] !== sel_for(d)) begin fails++; $display("FAIL blank_dp SEL%0d: got %b want %b", d, cap_sel[d], sel_for(d)); end
    end
    blank_lz = 1'b0; dp_mask = '0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic ok;
    int n = 0;
    load(24'd123456, 1'b1);
    din = 24'h654321; mode = 1'b0; din_vld = 1'b1;
    push_frame(24'h654321, 1'b0, 1'b0, '0);
    do begin
      ok = din_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    din_vld = 1'b0;
    tests++; if (n != DATA_W + 1) begin fails++; $display("FAIL b2b_wait: accepted after %0d cycles want %0d", n, DATA_W + 1); end
    tests++; if (din_rdy !== 1'b1) begin fails++; $display("FAIL b2b_rdy: got %b want 1", din_rdy); end
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL b2b DIG%0d: got %h want %h", d, cap_dig[d], e); end
    end
  endtask

  task automatic test_blink();
    int k;
    logic [SEL_W-1:0] es;
    blink_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      wait_slot();
      k  = cyc / SCAN;
      es = ((((k - 1) / BLINK) % 2) == 0) ? sel_for((k - 1) % SEL_W) : '1;
      tests++; if (SEL !== es) begin fails++; $display("FAIL blink_on slot%0d: got %b want %b", k, SEL, es); end
    end
    blink_en = 1'b0;
    for (int s = 0; s < 8; s++) begin
      wait_slot();
      k  = cyc / SCAN;
      es = sel_for((k - 1) % SEL_W);
      tests++; if (SEL !== es) begin fails++; $display("FAIL blink_off slot%0d: got %b want %b", k, SEL, es); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    load(24'd123456, 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    tests++; if (SEL !== 6'h3F) begin fails++; $display("FAIL rst_mid_sel: got %h want 3f", SEL); end
    tests++; if (DIG !== 8'hFF) begin fails++; $display("FAIL rst_mid_dig: got %h want ff", DIG); end
    tests++; if (din_rdy !== 1'b1) begin fails++; $display("FAIL rst_mid_rdy: got %b want 1", din_rdy); end
    @(negedge clk) rst_n = 1'b1;
    push_frame('0, 1'b0, 1'b0, '0);
    capture_frame();
    for (int d = 0; d < SEL_W; d++) begin
      e = exp_q.pop_front();
      tests++; if (cap_dig[d] !== e) begin fails++; $display("FAIL rst_mid DIG%0d: got %h want %h", d, cap_dig[d], e); end
      tests++; if (cap_sel[d] !== sel_for(d)) begin fails++; $display("FAIL rst_mid SEL%0d: got %b want %b", d, cap_sel[d], sel_for(d)); end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_blank_dp();
    test_back_to_back();
    test_blink();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
